ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/ram_arb_mux.sv | 61 ++++++
 rtl/ram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the CPU/DMA RAM arbiter: FSM state encoding and grant owner.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_ARB      = 2'd0,
        ST_DMA_LOCK = 2'd1,
        ST_CPU_SLOT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/ram_arb_mux.sv
// Owner-selected routing of request fields onto the RAM port and read data back
// to the granted requester only.
module ram_arb_mux
    import ram_arbiter_pkg::*;
#(
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter logic [2:0] DMA_RW_TYPE = 3'b010
) (
    input  logic              gnt_valid,
    input  owner_e            owner,
    input  logic              cpu_R_en,
    input  logic              cpu_W_en,
    input  logic [2:0]        cpu_RW_type,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              mem_R_en,
    output logic              mem_W_en,
    output logic [2:0]        mem_RW_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] dma_dout
);

    logic cpu_sel;
    logic dma_sel;

    assign cpu_sel = gnt_valid && (owner == OWN_CPU);
    assign dma_sel = gnt_valid && (owner == OWN_DMA);

    always_comb begin
        mem_R_en    = 1'b0;
        mem_W_en    = 1'b0;
        mem_RW_type = '0;
        mem_addr    = '0;
        mem_din     = '0;
        if (cpu_sel) begin
            // Both enables together means a store.
            mem_W_en    = cpu_W_en;
            mem_R_en    = cpu_R_en && !cpu_W_en;
            mem_RW_type = cpu_RW_type;
            mem_addr    = cpu_addr;
            mem_din     = cpu_din;
        end else if (dma_sel) begin
            mem_W_en    = dma_we;
            mem_R_en    = !dma_we;
            mem_RW_type = DMA_RW_TYPE;
            mem_addr    = dma_addr;
            mem_din     = dma_din;
        end
    end

    assign cpu_dout = cpu_sel ? mem_dout : '0;
    assign dma_dout = dma_sel ? mem_dout : '0;

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between a CPU MEM stage and a DMA engine with locked
// bursts bounded by BURST_MAX. Optional stall statistics under RAM_ARB_STATS_EN.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter int         BURST_MAX   = 8,
    parameter logic [2:0] DMA_RW_TYPE = 3'b010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_R_en,
    input  logic              cpu_W_en,
    input  logic [2:0]        cpu_RW_type,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_din,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_dout,
    output logic              mem_R_en,
    output logic              mem_W_en,
    output logic [2:0]        mem_RW_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              stat_conflict
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_stall_cnt
`endif
);

    localparam logic [BURST_CNT_W-1:0] BURST_MAX_C = BURST_MAX[BURST_CNT_W-1:0];

    arb_state_e             state_reg, state_next;
    owner_e                 last_grant_reg, last_grant_next;
    logic [BURST_CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic [BURST_CNT_W-1:0] burst_inc;
    logic                   cpu_req;
    logic                   cpu_granted;
    logic                   dma_granted;

    assign cpu_req   = cpu_R_en | cpu_W_en;
    assign burst_inc = burst_cnt_reg + 1'b1;

    // Grants are forced off while reset is held so no access leaks out mid-reset.
    always_comb begin
        cpu_granted     = 1'b0;
        dma_granted     = 1'b0;
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        burst_cnt_next  = burst_cnt_reg;
        if (rst_n) begin
            unique case (state_reg)
                ST_ARB: begin
                    if (cpu_req && dma_req) begin
                        cpu_granted = (last_grant_reg == OWN_DMA);
                        dma_granted = (last_grant_reg == OWN_CPU);
                    end else begin
                        cpu_granted = cpu_req;
                        dma_granted = dma_req;
                    end
                    burst_cnt_next = '0;
                    if (dma_granted && dma_lock) begin
                        state_next     = ST_DMA_LOCK;
                        burst_cnt_next = 1;
                    end
                end
                ST_DMA_LOCK: begin
                    if (dma_req) begin
                        dma_granted    = 1'b1;
                        burst_cnt_next = burst_inc;
                        if (!dma_lock) begin
                            state_next     = ST_ARB;
                            burst_cnt_next = '0;
                        end else if (burst_inc == BURST_MAX_C) begin
                            state_next     = cpu_req ? ST_CPU_SLOT : ST_ARB;
                            burst_cnt_next = '0;
                        end
                    end else begin
                        // DMA dropped out of its burst; the slot is not wasted.
                        cpu_granted    = cpu_req;
                        state_next     = ST_ARB;
                        burst_cnt_next = '0;
                    end
                end
                ST_CPU_SLOT: begin
                    cpu_granted = cpu_req;
                    dma_granted = !cpu_req && dma_req;
                    state_next  = ST_ARB;
                end
                default: state_next = ST_ARB;
            endcase
            if (cpu_granted) begin
                last_grant_next = OWN_CPU;
            end else if (dma_granted) begin
                last_grant_next = OWN_DMA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_ARB;
            last_grant_reg <= OWN_DMA;
            burst_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            burst_cnt_reg  <= burst_cnt_next;
        end
    end

    assign cpu_stall     = rst_n && cpu_req && !cpu_granted;
    assign dma_gnt       = dma_granted;
    assign stat_conflict = rst_n && cpu_req && dma_req;

    ram_arb_mux #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DMA_RW_TYPE (DMA_RW_TYPE)
    ) u_mux (
        .gnt_valid   (cpu_granted | dma_granted),
        .owner       (dma_granted ? OWN_DMA : OWN_CPU),
        .cpu_R_en    (cpu_R_en),
        .cpu_W_en    (cpu_W_en),
        .cpu_RW_type (cpu_RW_type),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_din     (dma_din),
        .mem_dout    (mem_dout),
        .mem_R_en    (mem_R_en),
        .mem_W_en    (mem_W_en),
        .mem_RW_type (mem_RW_type),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .cpu_dout    (cpu_dout),
        .dma_dout    (dma_dout)
    );

`ifdef RAM_ARB_STATS_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (cpu_stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stat_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table for single-cycle routing, plus
// sequences for startup conflict, burst limiting, reset abort and stall stats.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_R_en, cpu_W_en;
    logic [2:0]  cpu_RW_type;
    logic [31:0] cpu_addr, cpu_din, cpu_dout;
    logic        cpu_stall;
    logic        dma_req, dma_we, dma_lock;
    logic [31:0] dma_addr, dma_din, dma_dout;
    logic        dma_gnt;
    logic        mem_R_en, mem_W_en;
    logic [2:0]  mem_RW_type;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        stat_conflict;
`ifdef RAM_ARB_STATS_EN
    logic [15:0] stat_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W(32), .DATA_W(32), .BURST_MAX(8), .DMA_RW_TYPE(3'b010)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_R_en      (cpu_R_en),
        .cpu_W_en      (cpu_W_en),
        .cpu_RW_type   (cpu_RW_type),
        .cpu_addr      (cpu_addr),
        .cpu_din       (cpu_din),
        .cpu_dout      (cpu_dout),
        .cpu_stall     (cpu_stall),
        .dma_req       (dma_req),
        .dma_we        (dma_we),
        .dma_lock      (dma_lock),
        .dma_addr      (dma_addr),
        .dma_din       (dma_din),
        .dma_gnt       (dma_gnt),
        .dma_dout      (dma_dout),
        .mem_R_en      (mem_R_en),
        .mem_W_en      (mem_W_en),
        .mem_RW_type   (mem_RW_type),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .stat_conflict (stat_conflict)
`ifdef RAM_ARB_STATS_EN
        ,
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    typedef struct {
        logic        cpu_r, cpu_w;
        logic [2:0]  cpu_type;
        logic [31:0] cpu_a, cpu_d;
        logic        d_req, d_we, d_lock;
        logic [31:0] d_a, d_d, m_dout;
        logic        e_mr, e_mw;
        logic [2:0]  e_type;
        logic [31:0] e_addr, e_din, e_cdout;
        logic        e_stall, e_gnt;
        logic [31:0] e_ddout;
        logic        e_conf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_cpu(input logic r, input logic w, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] d);
        cpu_R_en = r; cpu_W_en = w; cpu_RW_type = t; cpu_addr = a; cpu_din = d;
    endtask

    task automatic drive_dma(input logic req, input logic we, input logic lock,
                             input logic [31:0] a, input logic [31:0] d);
        dma_req = req; dma_we = we; dma_lock = lock; dma_addr = a; dma_din = d;
    endtask

    task automatic idle();
        drive_cpu(0, 0, 3'd0, 32'h0, 32'h0);
        drive_dma(0, 0, 0, 32'h0, 32'h0);
        mem_dout = 32'h0;
    endtask

    // Hold reset across one edge, then release just after an edge so the
    // following window is the first post-reset cycle.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stall_run;
        logic seen_cpu;
        logic exp_dma;

        //  cpu_r cpu_w type     addr      din       dreq dwe dlock daddr     ddin      mdout
        //  e_mr e_mw e_type e_addr e_din e_cdout e_stall e_gnt e_ddout e_conf
        vecs[0] = '{0, 0, 3'b000, 32'h0,   32'h0,  0, 0, 0, 32'h0,   32'h0,  32'h1111,
                    0, 0, 3'b000, 32'h0,   32'h0,  32'h0,        0, 0, 32'h0,    0};
        vecs[1] = '{1, 0, 3'b010, 32'h100, 32'h55, 0, 0, 0, 32'h0,   32'h0,  32'hDEADBEEF,
                    1, 0, 3'b010, 32'h100, 32'h55, 32'hDEADBEEF, 0, 0, 32'h0,    0};
        vecs[2] = '{0, 1, 3'b001, 32'h200, 32'hAA, 1, 0, 0, 32'h300, 32'h77, 32'h1234,
                    1, 0, 3'b010, 32'h300, 32'h77, 32'h0,        1, 1, 32'h1234, 1};
        vecs[3] = '{0, 1, 3'b001, 32'h200, 32'hAA, 1, 0, 0, 32'h300, 32'h77, 32'h0,
                    0, 1, 3'b001, 32'h200, 32'hAA, 32'h0,        0, 0, 32'h0,    1};
        vecs[4] = '{1, 1, 3'b000, 32'h204, 32'hBB, 0, 0, 0, 32'h0,   32'h0,  32'h0,
                    0, 1, 3'b000, 32'h204, 32'hBB, 32'h0,        0, 0, 32'h0,    0};
        vecs[5] = '{0, 0, 3'b000, 32'h0,   32'h0,  1, 1, 0, 32'h400, 32'hCC, 32'h0,
                    0, 1, 3'b010, 32'h400, 32'hCC, 32'h0,        0, 1, 32'h0,    0};
        vecs[6] = '{1, 0, 3'b100, 32'h500, 32'h1,  1, 0, 0, 32'h600, 32'h2,  32'hCAFE,
                    1, 0, 3'b100, 32'h500, 32'h1,  32'hCAFE,     0, 0, 32'h0,    1};

        // Reset with both requesters active: nothing may reach the RAM.
        rst_n = 1'b0;
        idle();
        drive_cpu(1, 1, 3'b010, 32'h10, 32'h10);
        drive_dma(1, 1, 1, 32'h20, 32'h20);
        @(negedge clk);
        chk("rst_mem_W_en", 32'(mem_W_en), 32'h0);
        chk("rst_mem_R_en", 32'(mem_R_en), 32'h0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'h0);
        chk("rst_conflict", 32'(stat_conflict), 32'h0);
        $display("reset: mem_W_en=%0b stall=%0b gnt=%0b", mem_W_en, cpu_stall, dma_gnt);

        // Vector table, applied back-to-back from a fresh reset.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i != 0) next_cycle();
            drive_cpu(vecs[i].cpu_r, vecs[i].cpu_w, vecs[i].cpu_type, vecs[i].cpu_a, vecs[i].cpu_d);
            drive_dma(vecs[i].d_req, vecs[i].d_we, vecs[i].d_lock, vecs[i].d_a, vecs[i].d_d);
            mem_dout = vecs[i].m_dout;
            @(negedge clk);
            chk($sformatf("v%0d_mem_R_en", i), 32'(mem_R_en), 32'(vecs[i].e_mr));
            chk($sformatf("v%0d_mem_W_en", i), 32'(mem_W_en), 32'(vecs[i].e_mw));
            chk($sformatf("v%0d_mem_RW_type", i), 32'(mem_RW_type), 32'(vecs[i].e_type));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_mem_din", i), mem_din, vecs[i].e_din);
            chk($sformatf("v%0d_cpu_dout", i), cpu_dout, vecs[i].e_cdout);
            chk($sformatf("v%0d_cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_dma_gnt", i), 32'(dma_gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_dma_dout", i), dma_dout, vecs[i].e_ddout);
            chk($sformatf("v%0d_conflict", i), 32'(stat_conflict), 32'(vecs[i].e_conf));
            $display("vec %0d: addr=%h R=%0b W=%0b stall=%0b gnt=%0b", i, mem_addr,
                     mem_R_en, mem_W_en, cpu_stall, dma_gnt);
        end

        // First cycle after reset: CPU wins the conflict, DMA gets the next cycle.
        do_reset();
        drive_cpu(1, 0, 3'b010, 32'h100, 32'h0);
        drive_dma(1, 1, 0, 32'h800, 32'h99);
        @(negedge clk);
        chk("first_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("first_dma_gnt", 32'(dma_gnt), 32'h0);
        chk("first_conflict", 32'(stat_conflict), 32'h1);
        chk("first_mem_R_en", 32'(mem_R_en), 32'h1);
        $display("startup conflict c0: stall=%0b gnt=%0b", cpu_stall, dma_gnt);
        next_cycle();
        @(negedge clk);
        chk("second_dma_gnt", 32'(dma_gnt), 32'h1);
        chk("second_mem_W_en", 32'(mem_W_en), 32'h1);
        chk("second_cpu_stall", 32'(cpu_stall), 32'h1);
        $display("startup conflict c1: stall=%0b gnt=%0b", cpu_stall, dma_gnt);

        // Locked DMA burst of 12 against a continuously requesting CPU.
        do_reset();
        drive_cpu(1, 0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        chk("burst_pre_cpu", 32'(cpu_stall), 32'h0);
        stall_run = 0;
        seen_cpu  = 1'b0;
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            drive_cpu(1, 0, 3'b010, 32'h20, 32'h0);
            drive_dma(c < 13, 1, 1, 32'h1000 + 32'(c), 32'(c));
            @(negedge clk);
            exp_dma = (c != 8) && (c < 13);
            chk($sformatf("burst_c%0d_dma_gnt", c), 32'(dma_gnt), 32'(exp_dma));
            chk($sformatf("burst_c%0d_cpu_stall", c), 32'(cpu_stall), 32'(exp_dma));
            if (!exp_dma) chk($sformatf("burst_c%0d_mem_addr", c), mem_addr, 32'h20);
            if (cpu_stall && !seen_cpu) stall_run++;
            if (!cpu_stall) seen_cpu = 1'b1;
            $display("burst c%0d: gnt=%0b stall=%0b addr=%h", c, dma_gnt, cpu_stall, mem_addr);
        end
        chk("burst_stall_run", 32'(stall_run), 32'd8);

        // Reset asserted in the third cycle of a locked write burst.
        do_reset();
        drive_dma(1, 1, 1, 32'h2000, 32'h5);
        @(negedge clk);
        chk("abort_c0_gnt", 32'(dma_gnt), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("abort_c1_gnt", 32'(dma_gnt), 32'h1);
        next_cycle();
        drive_cpu(1, 0, 3'b010, 32'h30, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_W_en", 32'(mem_W_en), 32'h0);
        chk("abort_dma_gnt", 32'(dma_gnt), 32'h0);
        chk("abort_cpu_stall", 32'(cpu_stall), 32'h0);
        $display("abort: mem_W_en=%0b gnt=%0b", mem_W_en, dma_gnt);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_after_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("abort_after_dma_gnt", 32'(dma_gnt), 32'h0);
        chk("abort_after_mem_addr", mem_addr, 32'h30);
        next_cycle();
        @(negedge clk);
        chk("abort_after2_dma_gnt", 32'(dma_gnt), 32'h1);
        $display("abort release: conflict went to cpu then dma");

`ifdef RAM_ARB_STATS_EN
        // Continuous contention: 1 CPU grant per 9 cycles, 8 stalls each period.
        do_reset();
        drive_cpu(1, 0, 3'b010, 32'h40, 32'h0);
        drive_dma(1, 0, 1, 32'h3000, 32'h0);
        @(posedge clk);
        for (int c = 1; c < 9; c++) @(posedge clk);
        #1;
        chk("stats_first_period", 32'(stat_stall_cnt), 32'd8);
        for (int c = 9; c < 9 * 8750; c++) @(posedge clk);
        #1;
        chk("stats_saturated", 32'(stat_stall_cnt), 32'h0000FFFF);
        $display("stats: stat_stall_cnt=%h", stat_stall_cnt);
`endif

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
